// File: rtl/dcache_direct_mapped_pkg.sv
// Shared constants, FSM state encoding and a byte-lane helper for the
// direct-mapped write-back data cache.
package dcache_direct_mapped_pkg;

  localparam int OFFSET_W       = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int BYTES_PER_LINE = LINE_W / 8;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_LOOKUP,
    DC_WB_REQ,
    DC_WB_DATA,
    DC_RF_REQ,
    DC_RF_WAIT,
    DC_RESPOND
  } dc_state_e;

  // Place a 4-bit word store mask at its byte lanes within a line.
  function automatic logic [BYTES_PER_LINE-1:0] word_be(input logic [1:0] word,
                                                         input logic [3:0] we);
    return BYTES_PER_LINE'(we) << {word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_direct_mapped_array.sv
// Tag/valid/dirty/data storage: one asynchronous read port addressed by the
// registered request index, one write port with per-byte data enables.
module dcache_direct_mapped_array #(
  parameter int LINES     = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 22,
  parameter int LINE_BITS = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [LINE_BITS-1:0]   rd_data,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic                   wr_valid,
  input  logic                   wr_dirty,
  input  logic [LINE_BITS/8-1:0] wr_be,
  input  logic [LINE_BITS-1:0]   wr_data
);

  logic [LINES-1:0]     valid_bits;
  logic [LINES-1:0]     dirty_bits;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];

  assign rd_valid = valid_bits[rd_idx];
  assign rd_dirty = dirty_bits[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= wr_valid;
      dirty_bits[wr_idx] <= wr_dirty;
      tag_mem[wr_idx]    <= wr_tag;
    end
  end

  // Data has no reset; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < LINE_BITS / 8; b++) begin
        if (wr_be[b]) data_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache: request register,
// hit compare, byte merge and the miss-handling FSM.
module dcache_direct_mapped
  import dcache_direct_mapped_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BITS  = LINE_W,
  parameter int MEM_ADDR_W = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_re,
  input  logic [3:0]            cpu_we,
  input  logic [31:0]           cpu_din,
  output logic [31:0]           cpu_dout,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [MEM_ADDR_W-1:0] mem_req_addr,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_BITS-1:0]  mem_resp_data
);

  localparam int IDX_W      = $clog2(LINES);
  localparam int TAG_W      = 32 - OFFSET_W - IDX_W;
  localparam int LINE_BYTES = LINE_BITS / 8;

  dc_state_e state_reg, state_next;

  logic [TAG_W-1:0]  tag_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [1:0]        word_reg;
  logic [3:0]        we_reg;
  logic [31:0]       din_reg;
  logic              store_reg;
  logic [WORD_W-1:0] dout_reg;

  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]     wr_tag;
  logic [LINE_BYTES-1:0] wr_be;
  logic [LINE_BITS-1:0] wr_data;

  logic                  hit, accept, dout_show, unused_addr_bits;
  logic [LINE_BYTES-1:0] store_be;
  logic [LINE_BITS-1:0]  merged_line;
  logic [WORD_W-1:0]     rd_word;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign hit      = rd_valid && (rd_tag == tag_reg);
  assign accept   = (cpu_re || (cpu_we != 4'b0)) && !stall && (state_reg != DC_RESPOND);
  assign store_be = word_be(word_reg, we_reg);
  assign rd_word  = rd_data[word_reg*WORD_W +: WORD_W];
  assign mem_wdata = rd_data;
  assign cpu_dout  = dout_show ? rd_word : dout_reg;

  // Refill line with the pending store's bytes folded in, written in one go.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_merge
      assign merged_line[gi*8 +: 8] = (store_reg && store_be[gi]) ?
                                      din_reg[(gi % 4)*8 +: 8] : mem_resp_data[gi*8 +: 8];
    end
  endgenerate

  dcache_direct_mapped_array #(
    .LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_BITS(LINE_BITS)
  ) u_array (
    .clk(clk), .reset(reset),
    .rd_idx(idx_reg), .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(idx_reg), .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
    .wr_be(wr_be), .wr_data(wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_reg   <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      we_reg    <= '0;
      din_reg   <= '0;
      store_reg <= 1'b0;
    end else if (accept) begin
      tag_reg   <= cpu_addr[31 -: TAG_W];
      idx_reg   <= cpu_addr[OFFSET_W +: IDX_W];
      word_reg  <= cpu_addr[3:2];
      we_reg    <= cpu_we;
      din_reg   <= cpu_din;
      store_reg <= (cpu_we != 4'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DC_IDLE;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (dout_show) dout_reg <= rd_word;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DC_IDLE:    if (accept) state_next = DC_LOOKUP;
      DC_LOOKUP: begin
        if (hit)           state_next = accept ? DC_LOOKUP : DC_IDLE;
        else if (rd_dirty) state_next = DC_WB_REQ;
        else               state_next = DC_RF_REQ;
      end
      DC_WB_REQ:  if (mem_req_ready)   state_next = DC_WB_DATA;
      DC_WB_DATA: if (mem_wdata_ready) state_next = DC_RF_REQ;
      DC_RF_REQ:  if (mem_req_ready)   state_next = DC_RF_WAIT;
      DC_RF_WAIT: if (mem_resp_valid)  state_next = DC_RESPOND;
      DC_RESPOND: state_next = DC_IDLE;
      default:    state_next = DC_IDLE;
    endcase
  end

  always_comb begin
    stall           = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = MEM_ADDR_W'({tag_reg, idx_reg});
    mem_wdata_valid = 1'b0;
    dout_show       = 1'b0;
    wr_en           = 1'b0;
    wr_tag          = tag_reg;
    wr_valid        = 1'b1;
    wr_dirty        = 1'b0;
    wr_be           = '0;
    wr_data         = merged_line;
    case (state_reg)
      DC_LOOKUP: begin
        if (!hit) begin
          stall = 1'b1;
        end else if (store_reg) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
          wr_be    = store_be;
          wr_data  = {WORDS_PER_LINE{din_reg}};
        end else begin
          dout_show = 1'b1;
        end
      end
      DC_WB_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = MEM_ADDR_W'({rd_tag, idx_reg});
      end
      DC_WB_DATA: begin
        stall           = 1'b1;
        mem_wdata_valid = 1'b1;
        // Victim stays resident (tag unchanged) but is now clean.
        if (mem_wdata_ready) begin
          wr_en  = 1'b1;
          wr_tag = rd_tag;
        end
      end
      DC_RF_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      DC_RF_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          wr_en    = 1'b1;
          wr_dirty = store_reg;
          wr_be    = '1;
        end
      end
      DC_RESPOND: dout_show = !store_reg;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Randomized + directed self-checking bench for dcache_direct_mapped against a
// behavioural model (coherent memory image plus per-index residency table).
module tb_dcache_direct_mapped;

  logic         clk, reset;
  logic [31:0]  cpu_addr, cpu_din, cpu_dout;
  logic         cpu_re, stall;
  logic [3:0]   cpu_we;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_wdata_valid, mem_wdata_ready;
  logic [127:0] mem_wdata, mem_resp_data;
  logic         mem_resp_valid;

  dcache_direct_mapped dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int ntx = 0;

  // Backing memory and the CPU-visible image (lines stored to since last reset).
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] gold      [logic [27:0]];
  bit           mvalid [64];
  bit           mdirty [64];
  logic [21:0]  mtag   [64];

  logic [27:0]  rd_q [$];
  logic [27:0]  wb_addr_q [$];
  logic [127:0] wb_data_q [$];

  int  bp_left = 0, bp_seen = 0;
  bit  hold_resp = 0, rd_pending = 0;
  int  last_cyc;
  logic [31:0] last_dout;

  function automatic logic [127:0] init_line(input logic [27:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = {4'(k), a} ^ 32'h5A5A_5A5A;
    return l;
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_line(a);
  endfunction

  function automatic logic [127:0] gold_get(input logic [27:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_get(a);
  endfunction

  function automatic void gold_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [127:0] l;
    l = gold_get(a[31:4]);
    for (int b = 0; b < 4; b++)
      if (we[b]) l[a[3:2]*32 + b*8 +: 8] = d[b*8 +: 8];
    gold[a[31:4]] = l;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string why);
    errors++;
    $display("FAIL %s: wait bound expired", why);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "bench aborted");
  endtask

  // Memory side: random ready/backpressure, one-beat refills, handshake stability.
  logic        p_rq_v, p_rq_rdy, p_rq_rw, p_wd_v, p_wd_rdy;
  logic [27:0] p_rq_addr, wb_cur, rd_cur;
  logic [127:0] p_wd_data;
  int          rd_delay;

  initial begin
    mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    p_rq_v = 0; p_rq_rdy = 0; p_rq_rw = 0; p_rq_addr = '0;
    p_wd_v = 0; p_wd_rdy = 0; p_wd_data = '0; wb_cur = '0; rd_cur = '0; rd_delay = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        rd_pending = 0; p_rq_v = 0; p_wd_v = 0;
        mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0;
      end else begin
        if (p_rq_v && p_rq_rdy) begin
          if (p_rq_rw) begin
            wb_addr_q.push_back(p_rq_addr);
            wb_cur = p_rq_addr;
          end else begin
            rd_q.push_back(p_rq_addr);
            rd_cur = p_rq_addr; rd_pending = 1; rd_delay = $urandom_range(0, 3);
          end
        end else if (p_rq_v) begin
          chk("req_valid_held", mem_req_valid, 1'b1);
          chk("req_addr_held", mem_req_addr, p_rq_addr);
          chk("req_rw_held", mem_req_rw, p_rq_rw);
        end
        if (p_wd_v && p_wd_rdy) begin
          wb_data_q.push_back(p_wd_data);
          mem_store[wb_cur] = p_wd_data;
        end else if (p_wd_v) begin
          chk("wdata_valid_held", mem_wdata_valid, 1'b1);
          chk("wdata_held", mem_wdata, p_wd_data);
        end
        if (mem_resp_valid) begin
          mem_resp_valid = 0;
          rd_pending = 0;
        end else if (rd_pending && !hold_resp) begin
          if (rd_delay == 0) begin
            mem_resp_valid = 1;
            mem_resp_data  = mem_get(rd_cur);
          end else rd_delay--;
        end
        if (mem_req_valid && bp_left > 0) begin
          mem_req_ready = 0; bp_left--; bp_seen++;
        end else mem_req_ready = ($urandom_range(0, 2) != 0);
        mem_wdata_ready = ($urandom_range(0, 2) != 0);
        p_rq_v = mem_req_valid; p_rq_rdy = mem_req_ready; p_rq_rw = mem_req_rw; p_rq_addr = mem_req_addr;
        p_wd_v = mem_wdata_valid; p_wd_rdy = mem_wdata_ready; p_wd_data = mem_wdata;
      end
    end
  end

  // One CPU request: present it for one accept edge, wait out the stall, check.
  task automatic do_txn(input logic [31:0] a, input logic re, input logic [3:0] we, input logic [31:0] din);
    logic [27:0]  line, vline;
    logic [5:0]   ix;
    logic [21:0]  tg;
    logic [1:0]   w;
    logic         st, exp_hit, exp_wb;
    logic [127:0] vdata, gl;
    logic [31:0]  exp_word;
    int           cyc;
    line = a[31:4]; ix = a[9:4]; tg = a[31:10]; w = a[3:2]; st = (we != 4'b0);
    exp_hit = mvalid[ix] && (mtag[ix] == tg);
    exp_wb  = !exp_hit && mvalid[ix] && mdirty[ix];
    vline   = {mtag[ix], ix};
    vdata   = gold_get(vline);
    @(negedge clk);
    rd_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_din = din;
    @(negedge clk);
    cpu_re = 0; cpu_we = 4'b0;
    cyc = 0;
    while (stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) abort_run("txn_stall_timeout");
    gl = gold_get(line);
    exp_word = gl[w*32 +: 32];
    chk("hit_vs_miss", (cyc == 0), exp_hit);
    if (!st) chk("load_data", cpu_dout, exp_word);
    if (exp_hit) begin
      chk("hit_no_refill", rd_q.size(), 0);
      chk("hit_no_wb", wb_addr_q.size(), 0);
    end else begin
      chk("refill_count", rd_q.size(), 1);
      if (rd_q.size() > 0) chk("refill_addr", rd_q[0], line);
      chk("wb_count", wb_addr_q.size(), exp_wb);
      if (exp_wb && wb_addr_q.size() > 0 && wb_data_q.size() > 0) begin
        chk("wb_addr", wb_addr_q[0], vline);
        chk("wb_data", wb_data_q[0], vdata);
      end
    end
    if (st) gold_store(a, we, din);
    if (!exp_hit) begin
      mvalid[ix] = 1; mtag[ix] = tg; mdirty[ix] = st;
    end else if (st) mdirty[ix] = 1;
    last_cyc = cyc; last_dout = cpu_dout; ntx++;
    $display("txn %0d: %s addr=%h we=%b din=%h %s stall=%0d dout=%h", ntx, st ? "store" : "load ",
             a, we, din, exp_hit ? "hit " : "miss", cyc, cpu_dout);
  endtask

  logic [127:0] line_tmp, wb_tmp;
  logic [31:0]  ra;
  int           waitc;

  initial begin
    reset = 1; cpu_addr = '0; cpu_re = 0; cpu_we = 4'b0; cpu_din = '0;
    for (int i = 0; i < 64; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end
    line_tmp = init_line(28'h0000100);
    line_tmp[63:32] = 32'hDEADBEEF;
    mem_store[28'h0000100] = line_tmp;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_stall", stall, 1'b0);
    chk("reset_req_valid", mem_req_valid, 1'b0);
    chk("reset_wdata_valid", mem_wdata_valid, 1'b0);
    chk("reset_dout", cpu_dout, 32'h0);

    // Cold load, then store-hit and load-back.
    do_txn(32'h0000_1004, 1, 4'b0000, 32'h0);
    chk("cold_refill_addr_lit", rd_q.size() > 0 ? rd_q[0] : 28'hFFFFFFF, 28'h0000100);
    chk("cold_dout_lit", last_dout, 32'hDEADBEEF);
    do_txn(32'h0000_1004, 0, 4'b0011, 32'h0000_5678);
    chk("store_hit_no_stall", last_cyc, 0);
    do_txn(32'h0000_1004, 1, 4'b0000, 32'h0);
    chk("load_merged_lit", last_dout, 32'hDEAD5678);

    // Conflict miss evicting the dirty line.
    do_txn(32'h0000_1404, 1, 4'b0000, 32'h0);
    chk("conflict_wb_addr_lit", wb_addr_q.size() > 0 ? wb_addr_q[0] : 28'hFFFFFFF, 28'h0000100);
    wb_tmp = wb_data_q.size() > 0 ? wb_data_q[0] : '0;
    chk("conflict_wb_word1_lit", wb_tmp[63:32], 32'hDEAD5678);
    chk("conflict_refill_lit", rd_q.size() > 0 ? rd_q[0] : 28'hFFFFFFF, 28'h0000140);
    chk("conflict_stall_ge4", last_cyc >= 4, 1'b1);

    // Back-to-back hit loads on consecutive cycles.
    do_txn(32'h0000_100C, 1, 4'b0000, 32'h0);
    @(negedge clk);
    rd_q.delete(); wb_addr_q.delete();
    line_tmp = gold_get(28'h0000100);
    cpu_addr = 32'h0000_1000; cpu_re = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_stall", stall, 1'b0);
      chk("b2b_dout", cpu_dout, line_tmp[k*32 +: 32]);
      cpu_addr = 32'h0000_1004 + 32'(k*4);
      if (k == 2) cpu_re = 0;
    end
    chk("b2b_no_mem", rd_q.size() + wb_addr_q.size(), 0);
    $display("txn b2b: loads 0x1000/0x1004/0x1008 back to back");

    // Request-channel backpressure on a clean miss.
    bp_left = 5; bp_seen = 0;
    do_txn(32'h0000_2000, 1, 4'b0000, 32'h0);
    chk("bp_cycles_seen", bp_seen, 5);
    chk("bp_refill_lit", rd_q.size() > 0 ? rd_q[0] : 28'hFFFFFFF, 28'h0000200);

    // Dirty a line, then reset while the next miss waits for its refill.
    do_txn(32'h0000_1408, 0, 4'b1111, 32'hCAFEF00D);
    hold_resp = 1;
    @(negedge clk);
    rd_q.delete();
    cpu_addr = 32'h0000_3004; cpu_re = 1;
    @(negedge clk);
    cpu_re = 0;
    waitc = 0;
    while (rd_q.size() == 0 && waitc < 200) begin waitc++; @(negedge clk); end
    if (waitc >= 200) abort_run("reset_test_refill_wait");
    reset = 1;
    @(negedge clk);
    reset = 0; hold_resp = 0; rd_pending = 0;
    chk("midmiss_reset_stall", stall, 1'b0);
    chk("midmiss_reset_req_valid", mem_req_valid, 1'b0);
    for (int i = 0; i < 64; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
    gold.delete();
    $display("txn reset: asserted while refill of 0x3004 outstanding");
    do_txn(32'h0000_3004, 1, 4'b0000, 32'h0);
    chk("post_reset_miss", last_cyc > 0, 1'b1);
    do_txn(32'h0000_1408, 1, 4'b0000, 32'h0);
    chk("written_back_lit", last_dout, 32'hCAFEF00D);

    // Randomized mix over a few tags and indices to force hits and conflicts.
    for (int n = 0; n < 250; n++) begin
      logic [3:0] we;
      logic       re;
      int         kind;
      ra = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      kind = $urandom_range(0, 3);
      re = (kind != 2);
      we = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 9) == 0) bp_left = $urandom_range(1, 4);
      do_txn(ra, re, we, $urandom);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
